// File: rtl/cache_ram_ctrl_pkg.sv
// rtl/cache_ram_ctrl_pkg.sv - shared types and sizing helpers for cache_ram_ctrl
//
// Purpose: FSM state encoding, address-width helper and byte-enable width
//          expression used by the controller and its merge sub-module.
// Ports:   none (package).

package cache_ram_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Ceiling log2, never smaller than 1 so a 1-entry array still gets a port.
  function automatic int log2_ceil(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        bits = i + 1;
      end
    end
    return (bits < 1) ? 1 : bits;
  endfunction

  function automatic int be_width(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/cache_ram_fwd_merge.sv
// rtl/cache_ram_fwd_merge.sv - byte-wise merge of forwarded write data over RAM read data
//
// Purpose: when a forward hit is flagged, every byte enabled in fwd_be_i is
//          taken from fwd_data_i, every other byte from ram_data_i.
// Ports:   hit_i      - forward hit (registered write matches registered read)
//          fwd_data_i - data of the write being forwarded
//          fwd_be_i   - byte enables of that write
//          ram_data_i - raw RAM read data
//          merged_o   - merged read data

module cache_ram_fwd_merge
  import cache_ram_ctrl_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int BE    = be_width(WIDTH)
) (
  input  logic             hit_i,
  input  logic [WIDTH-1:0] fwd_data_i,
  input  logic [BE-1:0]    fwd_be_i,
  input  logic [WIDTH-1:0] ram_data_i,
  output logic [WIDTH-1:0] merged_o
);

  // Bit-wise loop so a WIDTH that is not a multiple of 8 still maps each
  // bit to the byte enable that covers it.
  always_comb begin
    merged_o = ram_data_i;
    for (int i = 0; i < WIDTH; i++) begin
      if (hit_i && fwd_be_i[i/8]) begin
        merged_o[i] = fwd_data_i[i];
      end
    end
  end

endmodule

// File: rtl/cache_ram_ctrl.sv
// rtl/cache_ram_ctrl.sv - clear sweep, write-port arbitration and read forwarding for a cache RAM
//
// Purpose: clears the array after reset or flush, arbitrates the single RAM
//          write port between refill (A) and store (B), and forwards the
//          write on the RAM bus into the read result, since the RAM's
//          mixed-port read-during-write result is undefined.
// Ports:   clk, rst                     - clock, async active-high reset
//          flushReq / initBusy          - start clear sweep / sweep in progress
//          aWrite* / aWriteGrant        - refill write request and grant
//          bWrite* / bWriteGrant        - store write request and grant
//          readAddress / readData       - read request, result one cycle later
//          ramReadAddress / ramReadData - RAM read port
//          ramWrite*                    - registered RAM write port

module cache_ram_ctrl
  import cache_ram_ctrl_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 256,
  parameter logic [WIDTH-1:0] INIT_VALUE   = '0,
  parameter int               STARVE_LIMIT = 4,
  localparam int              ADDR_WIDTH   = log2_ceil(DEPTH),
  localparam int              BE           = be_width(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flushReq,
  output logic                  initBusy,
  input  logic                  aWriteReq,
  input  logic [ADDR_WIDTH-1:0] aWriteAddress,
  input  logic [WIDTH-1:0]      aWriteData,
  input  logic [BE-1:0]         aWriteByteEnable,
  output logic                  aWriteGrant,
  input  logic                  bWriteReq,
  input  logic [ADDR_WIDTH-1:0] bWriteAddress,
  input  logic [WIDTH-1:0]      bWriteData,
  input  logic [BE-1:0]         bWriteByteEnable,
  output logic                  bWriteGrant,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  output logic [WIDTH-1:0]      readData,
  output logic [ADDR_WIDTH-1:0] ramReadAddress,
  input  logic [WIDTH-1:0]      ramReadData,
  output logic [ADDR_WIDTH-1:0] ramWriteAddress,
  output logic [WIDTH-1:0]      ramWriteData,
  output logic                  ramWriteEnable,
  output logic [BE-1:0]         ramWriteByteEnable
);

  localparam int SW = log2_ceil(STARVE_LIMIT);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  grant_a, grant_b;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;
  logic [BE-1:0]         wr_be_q, wr_be_d;

  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  fwd_en_q;
  logic [ADDR_WIDTH-1:0] fwd_addr_q;
  logic [WIDTH-1:0]      fwd_data_q;
  logic [BE-1:0]         fwd_be_q;
  logic                  init_rd_q;
  logic [WIDTH-1:0]      merged;

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    starve_d  = starve_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;

    case (state_q)
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = sweep_q;
        wr_data_d = INIT_VALUE;
        wr_be_d   = '1;
        sweep_d   = sweep_q + ADDR_WIDTH'(1);
        starve_d  = '0;
        if (sweep_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end
      end

      ST_RUN: begin
        if (flushReq) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
        end else begin
          // A has priority until B has watched STARVE_LIMIT-1 A grants go by.
          if (aWriteReq && bWriteReq) begin
            if (starve_q == SW'(STARVE_LIMIT - 1)) begin
              grant_b = 1'b1;
            end else begin
              grant_a = 1'b1;
            end
          end else begin
            grant_a = aWriteReq;
            grant_b = bWriteReq;
          end

          if (grant_b || !bWriteReq) begin
            starve_d = '0;
          end else if (grant_a) begin
            starve_d = starve_q + SW'(1);
          end

          if (grant_a) begin
            wr_en_d   = 1'b1;
            wr_addr_d = aWriteAddress;
            wr_data_d = aWriteData;
            wr_be_d   = aWriteByteEnable;
          end else if (grant_b) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bWriteAddress;
            wr_data_d = bWriteData;
            wr_be_d   = bWriteByteEnable;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      sweep_q   <= '0;
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
    end
  end

  // Snapshot of the write on the RAM bus during the read cycle; the RAM
  // commits it on the same edge it samples the read, so it must be forwarded.
  // init_rd_q comes out of reset set because initBusy is high during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q  <= '0;
      fwd_en_q   <= 1'b0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
      fwd_be_q   <= '0;
      init_rd_q  <= 1'b1;
    end else begin
      rd_addr_q  <= readAddress;
      fwd_en_q   <= wr_en_q;
      fwd_addr_q <= wr_addr_q;
      fwd_data_q <= wr_data_q;
      fwd_be_q   <= wr_be_q;
      init_rd_q  <= (state_q == ST_CLEAR);
    end
  end

  cache_ram_fwd_merge #(
    .WIDTH(WIDTH)
  ) u_merge (
    .hit_i     (fwd_en_q && (fwd_addr_q == rd_addr_q)),
    .fwd_data_i(fwd_data_q),
    .fwd_be_i  (fwd_be_q),
    .ram_data_i(ramReadData),
    .merged_o  (merged)
  );

  assign readData           = init_rd_q ? INIT_VALUE : merged;
  assign initBusy           = (state_q == ST_CLEAR);
  assign aWriteGrant        = grant_a;
  assign bWriteGrant        = grant_b;
  assign ramReadAddress     = readAddress;
  assign ramWriteEnable     = wr_en_q;
  assign ramWriteAddress    = wr_addr_q;
  assign ramWriteData       = wr_data_q;
  assign ramWriteByteEnable = wr_be_q;

endmodule
